// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: bundles the cache-side request/fill signals and the
// main-memory bus seen by cache_mem_arbiter. The "master" modport is the
// arbiter's view (it masters the memory); "slave" is the environment's view
// (cache controllers plus main memory).
interface cache_mem_arbiter_if #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int BLK_WORDS = 8
);
    localparam int WCNT_W = $clog2(BLK_WORDS);

    // cache controller side
    logic              i_miss_req;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss_req;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic              i_fill_we;
    logic              d_fill_we;
    logic [WCNT_W-1:0] fill_word;
    logic [DATA_W-1:0] fill_data;
    logic              i_fill_done;
    logic              d_fill_done;
    logic              d_wr_ack;
    // main memory side
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    // status
    logic              busy;

    modport master (
        input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
        output i_fill_we, d_fill_we, fill_word, fill_data,
        output i_fill_done, d_fill_done, d_wr_ack,
        output mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    modport slave (
        output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
        input  i_fill_we, d_fill_we, fill_word, fill_data,
        input  i_fill_done, d_fill_done, d_wr_ack,
        input  mem_en, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one pipelined, fixed-latency main memory between
// the I-cache miss path, the D-cache miss path and the D-cache write-through
// path. A miss is served as BLK_WORDS back-to-back word reads; returning words
// are steered to the granted cache. A write-through is a single memory write.
// Optional macro RR_ARB_EN: round-robin between the I side and the D side
// instead of the default fixed priority d_miss > d_wr > i_miss.
module cache_mem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int BLK_WORDS = 8
) (
    input  logic                clk,
    input  logic                rst,
    cache_mem_arbiter_if.master bus
);
    localparam int WCNT_W = $clog2(BLK_WORDS);
    // byte offset bits inside a block (word offset plus byte-in-word bit)
    localparam int OFF_W  = $clog2(BLK_WORDS * 2);
    localparam int BLK_W  = ADDR_W - OFF_W;
    localparam logic [WCNT_W:0]   C_BLK_CNT = (WCNT_W + 1)'(BLK_WORDS);
    localparam logic [WCNT_W-1:0] C_LAST_WD = WCNT_W'(BLK_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DONE  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [WCNT_W:0]     r_issue_cnt;
    logic [WCNT_W-1:0]   r_rcv_cnt;
    logic                r_grant_d;
    logic [BLK_W-1:0]    r_blk;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;

    logic w_d_side;
    logic w_pick_d;
    logic w_take_dmiss;
    logic w_take_dwr;
    logic w_take_imiss;
    logic w_issuing;
    logic w_last_rx;
    // block offset bits of the miss addresses are deliberately ignored
    logic w_unused_offsets;

    assign w_unused_offsets = ^{bus.i_miss_addr[OFF_W-1:0], bus.d_miss_addr[OFF_W-1:0]};

    assign w_d_side = bus.d_miss_req | bus.d_wr_req;

`ifdef RR_ARB_EN
    // 1 when the D side (miss or write) received the most recent grant
    logic r_last_d;
    assign w_pick_d = w_d_side & ~(bus.i_miss_req & r_last_d);
`else
    assign w_pick_d = w_d_side;
`endif

    assign w_take_dmiss = (r_state == ST_IDLE) & w_pick_d & bus.d_miss_req;
    assign w_take_dwr   = (r_state == ST_IDLE) & w_pick_d & ~bus.d_miss_req & bus.d_wr_req;
    assign w_take_imiss = (r_state == ST_IDLE) & ~w_pick_d & bus.i_miss_req;
    assign w_issuing    = (r_issue_cnt < C_BLK_CNT);
    assign w_last_rx    = bus.mem_rvalid & (r_rcv_cnt == C_LAST_WD);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: grant in IDLE, leave FILL after the last returned word
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take_dmiss | w_take_imiss) begin
                    w_next_state = ST_FILL;
                end else if (w_take_dwr) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_last_rx) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_FILL;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            ST_WRITE: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Grant latching, request latches and issue/receive word counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
            r_grant_d   <= 1'b0;
            r_blk       <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_issue_cnt <= '0;
                    r_rcv_cnt   <= '0;
                    if (w_take_dmiss) begin
                        r_blk     <= bus.d_miss_addr[ADDR_W-1:OFF_W];
                        r_grant_d <= 1'b1;
                    end else if (w_take_dwr) begin
                        r_wr_addr <= bus.d_wr_addr;
                        r_wr_data <= bus.d_wr_data;
                        r_grant_d <= 1'b1;
                    end else if (w_take_imiss) begin
                        r_blk     <= bus.i_miss_addr[ADDR_W-1:OFF_W];
                        r_grant_d <= 1'b0;
                    end else begin
                        r_grant_d <= r_grant_d;
                    end
                end
                ST_FILL: begin
                    if (w_issuing) begin
                        r_issue_cnt <= r_issue_cnt + (WCNT_W + 1)'(1);
                    end
                    if (bus.mem_rvalid) begin
                        r_rcv_cnt <= r_rcv_cnt + WCNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_issue_cnt <= '0;
                    r_rcv_cnt   <= '0;
                    r_grant_d   <= 1'b0;
                end
                ST_WRITE: begin
                    r_grant_d <= 1'b0;
                end
                default: begin
                    r_issue_cnt <= '0;
                    r_rcv_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef RR_ARB_EN
    // Remember which side was granted last so a tie goes to the other side
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (w_take_dmiss | w_take_dwr) begin
            r_last_d <= 1'b1;
        end else if (w_take_imiss) begin
            r_last_d <= 1'b0;
        end else begin
            r_last_d <= r_last_d;
        end
    end
`endif

    // Output decode: memory commands, fill steering, completion pulses
    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.i_fill_we   = 1'b0;
        bus.d_fill_we   = 1'b0;
        bus.fill_word   = '0;
        bus.fill_data   = '0;
        bus.i_fill_done = 1'b0;
        bus.d_fill_done = 1'b0;
        bus.d_wr_ack    = 1'b0;
        bus.busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_FILL: begin
                if (w_issuing) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = {r_blk, r_issue_cnt[WCNT_W-1:0], 1'b0};
                end else begin
                    bus.mem_en   = 1'b0;
                end
                if (bus.mem_rvalid) begin
                    bus.d_fill_we = r_grant_d;
                    bus.i_fill_we = ~r_grant_d;
                    bus.fill_word = r_rcv_cnt;
                    bus.fill_data = bus.mem_rdata;
                end else begin
                    bus.fill_word = '0;
                end
            end
            ST_DONE: begin
                if (r_grant_d) begin
                    bus.d_fill_done = 1'b1;
                end else begin
                    bus.i_fill_done = 1'b1;
                end
            end
            ST_WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = r_wr_addr;
                bus.mem_wdata = r_wr_data;
                bus.d_wr_ack  = 1'b1;
            end
            default: begin
                bus.mem_en = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: drives cache requests into cache_mem_arbiter against a
// fixed-latency memory model and compares every output, every cycle, with a
// timeline predicted from the arbitration and latency rules.
module tb_cache_mem_arbiter;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int BW = 8;
    localparam int WW = 3;
    localparam int L  = 4;

    typedef struct packed {
        logic          busy;
        logic          mem_en;
        logic          mem_wr;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
        logic          i_we;
        logic          d_we;
        logic [WW-1:0] word;
        logic [DW-1:0] fdata;
        logic          i_done;
        logic          d_done;
        logic          ack;
    } outs_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .BLK_WORDS(BW)) bus();

    cache_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BLK_WORDS(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // memory contents are a fixed scramble of the address
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        logic [DW-1:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    // memory: every read issued in cycle c answers in cycle c+L; never reset
    logic [L-1:0]  pv = '0;
    logic [AW-1:0] pa [L];
    always @(posedge clk) begin
        pv    <= {pv[L-2:0], bus.mem_en & ~bus.mem_wr};
        pa[0] <= bus.mem_addr;
        for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
    end
    assign bus.mem_rvalid = pv[L-1];
    assign bus.mem_rdata  = pv[L-1] ? mem_fn(pa[L-1]) : 16'h0000;

    // ---------------- reference model ----------------
    outs_t exp_a [0:127];
    int    exp_len;
    bit    m_last_d = 1'b0;

    function automatic void add_fill(input int t, input bit to_d, input logic [AW-1:0] a);
        logic [AW-1:0] base;
        logic [AW-1:0] wa;
        base = a & 16'hFFF0;
        for (int c = t + 1; c <= t + BW + L + 1; c++) exp_a[c].busy = 1'b1;
        for (int w = 0; w < BW; w++) begin
            wa = base + AW'(2 * w);
            exp_a[t+1+w].mem_en   = 1'b1;
            exp_a[t+1+w].mem_addr = wa;
            exp_a[t+1+L+w].i_we   = ~to_d;
            exp_a[t+1+L+w].d_we   = to_d;
            exp_a[t+1+L+w].word   = WW'(w);
            exp_a[t+1+L+w].fdata  = mem_fn(wa);
        end
        if (to_d) exp_a[t+BW+L+1].d_done = 1'b1;
        else      exp_a[t+BW+L+1].i_done = 1'b1;
    endfunction

    // requests all raised in cycle 0 while idle; predict the whole timeline
    function automatic void model_build(input bit dm, input logic [AW-1:0] dma,
                                        input bit dw, input logic [AW-1:0] dwa,
                                        input logic [DW-1:0] dwd,
                                        input bit im, input logic [AW-1:0] ima);
        int t;
        bit pend_d;
        bit pend_i;
        bit pick_d;
        t = 0;
        pend_d = dm | dw;
        pend_i = im;
        for (int i = 0; i < 128; i++) exp_a[i] = '0;
        while (pend_d || pend_i) begin
`ifdef RR_ARB_EN
            pick_d = pend_d && !(pend_i && m_last_d);
`else
            pick_d = pend_d;
`endif
            if (pick_d) begin
                m_last_d = 1'b1;
                pend_d = 1'b0;
                if (dm) begin
                    add_fill(t, 1'b1, dma);
                    t = t + BW + L + 2;
                end else begin
                    exp_a[t+1].busy      = 1'b1;
                    exp_a[t+1].mem_en    = 1'b1;
                    exp_a[t+1].mem_wr    = 1'b1;
                    exp_a[t+1].mem_addr  = dwa;
                    exp_a[t+1].mem_wdata = dwd;
                    exp_a[t+1].ack       = 1'b1;
                    t = t + 2;
                end
            end else begin
                m_last_d = 1'b0;
                pend_i = 1'b0;
                add_fill(t, 1'b0, ima);
                t = t + BW + L + 2;
            end
        end
        exp_len = t + 1;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic outs_t sample_outs();
        outs_t o;
        o.busy = bus.busy; o.mem_en = bus.mem_en; o.mem_wr = bus.mem_wr;
        o.mem_addr = bus.mem_addr; o.mem_wdata = bus.mem_wdata;
        o.i_we = bus.i_fill_we; o.d_we = bus.d_fill_we; o.word = bus.fill_word;
        o.fdata = bus.fill_data; o.i_done = bus.i_fill_done;
        o.d_done = bus.d_fill_done; o.ack = bus.d_wr_ack;
        return o;
    endfunction

    task automatic apply_reqs(input bit dm, input logic [AW-1:0] dma,
                              input bit dw, input logic [AW-1:0] dwa,
                              input logic [DW-1:0] dwd,
                              input bit im, input logic [AW-1:0] ima);
        bus.d_miss_req = dm; bus.d_miss_addr = dma;
        bus.d_wr_req = dw; bus.d_wr_addr = dwa; bus.d_wr_data = dwd;
        bus.i_miss_req = im; bus.i_miss_addr = ima;
    endtask

    // sample one cycle's outputs, then act as requesters for the next cycle
    task automatic run_cycle(output outs_t o);
        @(negedge clk);
        o = sample_outs();
        @(posedge clk);
        #1;
        if (o.d_done) bus.d_miss_req = 1'b0;
        if (o.i_done) bus.i_miss_req = 1'b0;
        if (o.ack)    bus.d_wr_req   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        outs_t o;
        rst = 1'b1;
        apply_reqs(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            apply_reqs(c[0], 16'h1111, 1'b0, '0, '0, 1'b1, 16'h2222);
            run_cycle(o);
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", c, o, outs_t'('0));
            end
        end
        apply_reqs(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        rst = 1'b0;
        m_last_d = 1'b0;
    endtask

    task automatic test_i_miss_alone();
        outs_t o;
        model_build(1'b0, '0, 1'b0, '0, '0, 1'b1, 16'h1234);
        apply_reqs(1'b0, '0, 1'b0, '0, '0, 1'b1, 16'h1234);
        for (int c = 0; c < exp_len; c++) begin
            run_cycle(o);
            checks++;
            if (o !== exp_a[c]) begin
                errors++;
                $display("FAIL i_miss_alone cycle %0d: got %h expected %h", c, o, exp_a[c]);
            end
        end
    endtask

    task automatic test_dual_miss();
        outs_t o;
        model_build(1'b1, 16'h8000, 1'b0, '0, '0, 1'b1, 16'h0040);
        apply_reqs(1'b1, 16'h8000, 1'b0, '0, '0, 1'b1, 16'h0040);
        for (int c = 0; c < exp_len; c++) begin
            run_cycle(o);
            checks++;
            if (o !== exp_a[c]) begin
                errors++;
                $display("FAIL dual_miss cycle %0d: got %h expected %h", c, o, exp_a[c]);
            end
        end
    endtask

    task automatic test_write();
        outs_t o;
        model_build(1'b0, '0, 1'b1, 16'h0102, 16'hBEEF, 1'b0, '0);
        apply_reqs(1'b0, '0, 1'b1, 16'h0102, 16'hBEEF, 1'b0, '0);
        for (int c = 0; c < exp_len; c++) begin
            run_cycle(o);
            checks++;
            if (o !== exp_a[c]) begin
                errors++;
                $display("FAIL write cycle %0d: got %h expected %h", c, o, exp_a[c]);
            end
        end
    endtask

    task automatic test_top_block();
        outs_t o;
        model_build(1'b1, 16'hFFF7, 1'b0, '0, '0, 1'b0, '0);
        apply_reqs(1'b1, 16'hFFF7, 1'b0, '0, '0, 1'b0, '0);
        for (int c = 0; c < exp_len; c++) begin
            run_cycle(o);
            checks++;
            if (o !== exp_a[c]) begin
                errors++;
                $display("FAIL top_block cycle %0d: got %h expected %h", c, o, exp_a[c]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        outs_t o;
        model_build(1'b0, '0, 1'b0, '0, '0, 1'b1, 16'h2468);
        // reset sampled at the end of cycle 6 wipes everything from cycle 7 on
        for (int c = 7; c < 128; c++) exp_a[c] = '0;
        exp_len = 16;
        m_last_d = 1'b0;
        apply_reqs(1'b0, '0, 1'b0, '0, '0, 1'b1, 16'h2468);
        for (int c = 0; c < exp_len; c++) begin
            run_cycle(o);
            checks++;
            if (o !== exp_a[c]) begin
                errors++;
                $display("FAIL reset_mid_fill cycle %0d: got %h expected %h", c, o, exp_a[c]);
            end
            if (c == 5) begin
                rst = 1'b1;
                bus.i_miss_req = 1'b0;
            end
            if (c == 6) rst = 1'b0;
        end
    endtask

    task automatic test_alternate();
        outs_t o;
        for (int r = 0; r < 2; r++) begin
            model_build(1'b1, 16'h4A00 + AW'(r * 16'h0100), 1'b0, '0, '0,
                        1'b1, 16'h0C30 + AW'(r * 16'h0010));
            apply_reqs(1'b1, 16'h4A00 + AW'(r * 16'h0100), 1'b0, '0, '0,
                       1'b1, 16'h0C30 + AW'(r * 16'h0010));
            for (int c = 0; c < exp_len; c++) begin
                run_cycle(o);
                checks++;
                if (o !== exp_a[c]) begin
                    errors++;
                    $display("FAIL alternate round %0d cycle %0d: got %h expected %h", r, c, o, exp_a[c]);
                end
            end
        end
    endtask

    task automatic test_random();
        outs_t         o;
        int            kind;
        bit            dm, dw, im;
        logic [AW-1:0] dma, dwa, ima;
        logic [DW-1:0] dwd;
        for (int n = 0; n < 24; n++) begin
            kind = int'($urandom_range(0, 4));
            dm = (kind == 0) || (kind == 3);
            dw = (kind == 1) || (kind == 4);
            im = (kind >= 2);
            dma = AW'($urandom); dwa = AW'($urandom);
            ima = AW'($urandom); dwd = DW'($urandom);
            model_build(dm, dma, dw, dwa, dwd, im, ima);
            apply_reqs(dm, dma, dw, dwa, dwd, im, ima);
            for (int c = 0; c < exp_len; c++) begin
                run_cycle(o);
                checks++;
                if (o !== exp_a[c]) begin
                    errors++;
                    $display("FAIL random #%0d cycle %0d: got %h expected %h", n, c, o, exp_a[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_miss_alone();
        test_dual_miss();
        test_write();
        test_top_block();
        test_reset_mid_fill();
        test_alternate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single multi-cycle main memory between the I-cache miss path, the D-cache miss path and the D-cache write-through path.
- Sequences each cache-block fill as pipelined word reads and steers returning words to the granted cache.
- Issues write-through stores as single-cycle memory writes.
- Sits between the two cache controllers and the main memory module in the pipelined cpu.

Parameters:
- DATA_W, 16, memory/cache word width in bits
- ADDR_W, 16, byte address width
- BLK_WORDS, 8, words per cache block (power of 2); WCNT_W = log2(BLK_WORDS)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_miss_req  in  1  I-cache miss, held until i_fill_done
- i_miss_addr  in  ADDR_W  I-cache miss byte address
- d_miss_req  in  1  D-cache miss, held until d_fill_done
- d_miss_addr  in  ADDR_W  D-cache miss byte address
- d_wr_req  in  1  D write-through request, held until d_wr_ack
- d_wr_addr  in  ADDR_W  write byte address
- d_wr_data  in  DATA_W  write data
- i_fill_we  out  1  I-cache fill word strobe
- d_fill_we  out  1  D-cache fill word strobe
- fill_word  out  WCNT_W  index of the word being filled
- fill_data  out  DATA_W  fill word data
- i_fill_done  out  1  one-cycle pulse, I fill complete
- d_fill_done  out  1  one-cycle pulse, D fill complete
- d_wr_ack  out  1  one-cycle pulse, write issued
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  read data valid (fixed memory latency, one result per issued read)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, checked every clk edge:
  - state goes to IDLE; issue_cnt, rcv_cnt and grant clear.
  - All outputs are 0.
  - A reset during FILL abandons the fill; mem_rvalid arriving afterwards is ignored.
- States and transitions:
  - IDLE: sample requests. Fixed priority is d_miss_req > d_wr_req > i_miss_req.
  - Miss grant: latch blk = miss_addr[ADDR_W-1:log2(BLK_WORDS*2)], latch grant, then go to FILL.
  - Write grant: latch d_wr_addr and d_wr_data, then go to WRITE.
  - No request: stay in IDLE.
  - FILL:
    - While issue_cnt < BLK_WORDS, each cycle drive mem_en=1, mem_wr=0 and mem_addr = {blk, issue_cnt, 1'b0}, then increment issue_cnt.
    - Once issue_cnt reaches BLK_WORDS, mem_en=0.
    - On mem_rvalid: assert the granted cache's fill_we, fill_word = rcv_cnt, fill_data = mem_rdata (combinational pass-through, same cycle), then increment rcv_cnt.
    - After the valid with rcv_cnt == BLK_WORDS-1, go to DONE.
  - DONE: one cycle. Pulse the granted cache's fill_done, clear counters, go to IDLE. Requests are ignored in DONE.
  - WRITE: one cycle. Drive mem_en=1, mem_wr=1, mem_addr and mem_wdata from the latched values, pulse d_wr_ack, go to IDLE.
- Requester rules:
  - A requester drops its req the cycle after its done/ack pulse.
  - d_miss_req and d_wr_req are never high together.
- mem_rvalid outside FILL is ignored. No fill_we is asserted for the non-granted side.
- Address handling:
  - Miss address bit 0 and the offset bits are ignored.
  - Block addressing never carries; blk 0xFFF gives addresses 0xFFF0..0xFFFE.
- Latency, for memory latency L with the request seen in IDLE at cycle 0:
  - reads issue in cycles 1..BLK_WORDS;
  - data arrives in cycles 1+L..BLK_WORDS+L;
  - done pulses at cycle BLK_WORDS+L+1;
  - IDLE is next available at BLK_WORDS+L+2.
- Write: ack in cycle 1, IDLE again at cycle 2.
- Requests arriving while busy wait in IDLE evaluation. There is no queueing beyond the held req lines.

Optional Feature:
- RR_ARB_EN defined: arbitration between I miss and D side (D miss or D write) is round-robin. A last_grant flag updates on each grant; on a simultaneous request the side not served last wins. d_miss_req still beats d_wr_req.
- RR_ARB_EN undefined: fixed priority d_miss > d_wr > i_miss.

Test Plan:
- I miss 0x1234 alone, L=4 -> mem_addr 0x1230,0x1232..0x123E in cycles 1-8; i_fill_we cycles 5-12 with fill_word 0..7; i_fill_done cycle 13; d_fill_we never set.
- I miss 0x0040 and D miss 0x8000 in the same cycle -> D fill 0x8000..0x800E first, d_fill_done cycle 13; I fill issues 0x0040 from cycle 15.
- d_wr_req addr 0x0102 data 0xBEEF in IDLE -> cycle 1: mem_en=1, mem_wr=1, mem_addr 0x0102, mem_wdata 0xBEEF, d_wr_ack=1; busy=0 at cycle 2.
- rst asserted in cycle 6 of an I fill -> next cycle all outputs 0 and busy=0; the remaining mem_rvalid pulses produce no fill_we.
- D miss 0xFFF7 -> addresses 0xFFF0..0xFFFE, no wrap past 0xFFFE.
- RR_ARB_EN defined, I and D misses held continuously (re-raised after each done) -> grants alternate D, I, D, I.
